// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter: shares one dcache port between m0 (LSU) and m1 (DMA/debug) with burst-locked grants and in-order read-response steering.
// Optional macros: DCACHE_ARB_ROUND_ROBIN_EN (round-robin IDLE ties), DCACHE_ARB_CHECK_EMPTY_POP (sim-only $error on response with empty ID FIFO).
module dcache_port_arbiter #(
  parameter int RD_FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m0_request,
  output logic        m0_ready,
  input  logic        m0_write,
  input  logic [31:0] m0_address,
  input  logic        m0_burst,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_wdata,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic [8:0]  m0_rtag,
  input  logic        m1_request,
  output logic        m1_ready,
  input  logic        m1_write,
  input  logic [31:0] m1_address,
  input  logic        m1_burst,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_wdata,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic [8:0]  m1_rtag,
  output logic        dc_request,
  input  logic        dc_ready,
  output logic        dc_write,
  output logic [31:0] dc_address,
  output logic        dc_burst,
  output logic [3:0]  dc_wstrb,
  output logic [31:0] dc_wdata,
  input  logic        dc_rvalid,
  input  logic [31:0] dc_rdata,
  input  logic [8:0]  dc_rtag
);

  localparam int PW = $clog2(RD_FIFO_DEPTH);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(RD_FIFO_DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t                   state;
  logic                     owner;
  logic                     grant;
  logic                     tie_winner;
  logic                     accept;
  logic                     push;
  logic                     pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [PW:0]              count;
  logic [PW-1:0]            wr_ptr;
  logic [PW-1:0]            rd_ptr;
  logic [RD_FIFO_DEPTH-1:0] id_mem;
  logic                     head_id;
  logic                     sel_request;
  logic                     sel_write;
  logic                     sel_burst;
  logic [31:0]              sel_address;
  logic [31:0]              sel_wdata;
  logic [3:0]               sel_wstrb;
  logic [31:0]              rdata_q;
  logic [8:0]               rtag_q;

`ifdef DCACHE_ARB_ROUND_ROBIN_EN
  logic rr_last;

  // rr_last starts at 1 so the first tie after reset goes to m0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_last <= 1'b1;
    end else if (accept && !sel_burst) begin
      rr_last <= grant;
    end
  end

  assign tie_winner = ~rr_last;
`else
  assign tie_winner = 1'b0;
`endif

  always_comb begin
    grant = 1'b0;
    if (state == LOCK) begin
      grant = owner;
    end else if (m0_request && m1_request) begin
      grant = tie_winner;
    end else if (m1_request) begin
      grant = 1'b1;
    end
  end

  always_comb begin
    sel_request = m0_request;
    sel_write   = m0_write;
    sel_burst   = m0_burst;
    sel_address = m0_address;
    sel_wdata   = m0_wdata;
    sel_wstrb   = m0_wstrb;
    if (grant) begin
      sel_request = m1_request;
      sel_write   = m1_write;
      sel_burst   = m1_burst;
      sel_address = m1_address;
      sel_wdata   = m1_wdata;
      sel_wstrb   = m1_wstrb;
    end
  end

  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  assign head_id    = id_mem[rd_ptr];

  // Reset gates the handshake combinationally so nothing is issued while held.
  assign dc_request = reset && sel_request && !(!sel_write && fifo_full);
  assign m0_ready   = reset && !grant && dc_ready && !(!m0_write && fifo_full);
  assign m1_ready   = reset &&  grant && dc_ready && !(!m1_write && fifo_full);

  assign dc_write   = sel_write;
  assign dc_address = sel_address;
  assign dc_burst   = sel_burst;
  assign dc_wstrb   = sel_wstrb;
  assign dc_wdata   = sel_wdata;

  assign accept = dc_request && dc_ready;
  assign push   = accept && !sel_write;
  assign pop    = dc_rvalid && !fifo_empty;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      owner <= 1'b0;
    end else if (accept) begin
      case (state)
        IDLE: begin
          if (sel_burst) begin
            state <= LOCK;
            owner <= grant;
          end
        end
        LOCK: begin
          if (!sel_burst) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      id_mem <= '0;
    end else begin
      if (push) begin
        id_mem[wr_ptr] <= grant;
        wr_ptr         <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Responses with no outstanding read (e.g. stale after reset) are dropped here.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      rdata_q   <= '0;
      rtag_q    <= '0;
    end else begin
      m0_rvalid <= pop && !head_id;
      m1_rvalid <= pop &&  head_id;
      if (pop) begin
        rdata_q <= dc_rdata;
        rtag_q  <= dc_rtag;
      end
    end
  end

  assign m0_rdata = rdata_q;
  assign m1_rdata = rdata_q;
  assign m0_rtag  = rtag_q;
  assign m1_rtag  = rtag_q;

`ifdef DCACHE_ARB_CHECK_EMPTY_POP
  always @(posedge clock) begin
    if (reset && dc_rvalid && fifo_empty) begin
      $error("dcache_port_arbiter: read response with no outstanding read, dropped");
    end
  end
`endif

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Bench for dcache_port_arbiter: dcache model with programmable latency, read-response scoreboard, directed grant/lock/stall/reset cases.
module tb_dcache_port_arbiter;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clock;
  logic        reset;
  logic        m0_request, m0_ready, m0_write, m0_burst, m0_rvalid;
  logic [31:0] m0_address, m0_wdata, m0_rdata;
  logic [3:0]  m0_wstrb;
  logic [8:0]  m0_rtag;
  logic        m1_request, m1_ready, m1_write, m1_burst, m1_rvalid;
  logic [31:0] m1_address, m1_wdata, m1_rdata;
  logic [3:0]  m1_wstrb;
  logic [8:0]  m1_rtag;
  logic        dc_request, dc_ready, dc_write, dc_burst, dc_rvalid;
  logic [31:0] dc_address, dc_wdata, dc_rdata;
  logic [3:0]  dc_wstrb;
  logic [8:0]  dc_rtag;

  typedef struct {
    logic        id;
    logic [8:0]  tag;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    int          due;
    logic [8:0]  tag;
    logic [31:0] data;
  } dcrsp_t;

  exp_t   sb[$];
  dcrsp_t dq[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     lat = 3;
  int     rv_count = 0;
  int     rv_before;

  dcache_port_arbiter #(.RD_FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .m0_request(m0_request), .m0_ready(m0_ready), .m0_write(m0_write), .m0_address(m0_address),
    .m0_burst(m0_burst), .m0_wstrb(m0_wstrb), .m0_wdata(m0_wdata),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rtag(m0_rtag),
    .m1_request(m1_request), .m1_ready(m1_ready), .m1_write(m1_write), .m1_address(m1_address),
    .m1_burst(m1_burst), .m1_wstrb(m1_wstrb), .m1_wdata(m1_wdata),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rtag(m1_rtag),
    .dc_request(dc_request), .dc_ready(dc_ready), .dc_write(dc_write), .dc_address(dc_address),
    .dc_burst(dc_burst), .dc_wstrb(dc_wstrb), .dc_wdata(dc_wdata),
    .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata), .dc_rtag(dc_rtag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input int m, input bit req, input bit wr, input logic [31:0] a,
                       input bit bu, input logic [31:0] wd);
    if (m == 0) begin
      m0_request = req; m0_write = wr; m0_address = a; m0_burst = bu; m0_wdata = wd; m0_wstrb = 4'hF;
    end else begin
      m1_request = req; m1_write = wr; m1_address = a; m1_burst = bu; m1_wdata = wd; m1_wstrb = 4'hF;
    end
  endtask

  // Present one beat from master m and hold it until accepted (bounded).
  task automatic beat(input int m, input bit wr, input logic [31:0] a, input bit bu, input logic [31:0] wd);
    bit ok;
    ok = 1'b0;
    @(negedge clock);
    drive(m, 1'b1, wr, a, bu, wd);
    for (int i = 0; i < 40; i++) begin
      #1;
      ok = (m == 0) ? m0_ready : m1_ready;
      if (ok) break;
      @(negedge clock);
    end
    chk("beat_accept", {31'd0, ok}, 32'd1);
    @(posedge clock);
    #1;
    drive(m, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0 && dq.size() == 0) break;
      @(posedge clock);
    end
    repeat (2) @(posedge clock);
    chk("drain_pending", sb.size(), 32'd0);
  endtask

  always @(posedge clock) cyc++;

  // dcache model: returns reads in order after 'lat' cycles; tag echoed from wdata[8:0].
  always @(negedge clock) begin
    dcrsp_t e;
    dc_rvalid = 1'b0;
    if (dq.size() > 0 && dq[0].due <= cyc) begin
      e = dq.pop_front();
      dc_rvalid = 1'b1;
      dc_rdata  = e.data;
      dc_rtag   = e.tag;
    end
  end

  // Handshakes are stable from negedge to the next posedge; sample them here.
  always @(negedge clock) begin
    #2;
    if (reset) begin
      if (m0_request && m0_ready && !m0_write) sb.push_back('{1'b0, m0_wdata[8:0], m0_address ^ KEY});
      if (m1_request && m1_ready && !m1_write) sb.push_back('{1'b1, m1_wdata[8:0], m1_address ^ KEY});
      if (dc_request && dc_ready && !dc_write) dq.push_back('{cyc + 1 + lat, dc_wdata[8:0], dc_address ^ KEY});
    end
  end

  always @(posedge clock) begin
    exp_t e;
    #1;
    if (m0_rvalid || m1_rvalid) begin
      rv_count++;
      chk("rsp_after_dc_rvalid", {31'd0, dc_rvalid}, 32'd1);
      chk("rsp_onehot", {31'd0, m0_rvalid & m1_rvalid}, 32'd0);
      if (sb.size() == 0) begin
        chk("rsp_unexpected", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_route", {31'd0, m1_rvalid}, {31'd0, e.id});
        chk("rsp_tag_m0", {23'd0, m0_rtag}, {23'd0, e.tag});
        chk("rsp_tag_m1", {23'd0, m1_rtag}, {23'd0, e.tag});
        chk("rsp_data_m0", m0_rdata, e.data);
        chk("rsp_data_m1", m1_rdata, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g;
    reset = 1'b0;
    dc_ready = 1'b1;
    dc_rvalid = 1'b0;
    dc_rdata = '0;
    dc_rtag = '0;
    drive(0, 1'b1, 1'b0, 32'h10, 1'b0, 32'h1);
    drive(1, 1'b1, 1'b0, 32'h14, 1'b0, 32'h2);

    // Reset state with both masters requesting
    repeat (2) @(negedge clock);
    #1;
    chk("rst_dc_request", {31'd0, dc_request}, 32'd0);
    chk("rst_m0_ready", {31'd0, m0_ready}, 32'd0);
    chk("rst_m1_ready", {31'd0, m1_ready}, 32'd0);
    chk("rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    chk("rst_rdata", m0_rdata | m1_rdata, 32'd0);
    chk("rst_rtag", {23'd0, m0_rtag | m1_rtag}, 32'd0);
    drive(0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Ties: both request single-beat writes every cycle
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      drive(0, 1'b1, 1'b1, 32'h1000 + 32'(i), 1'b0, 32'hAA);
      drive(1, 1'b1, 1'b1, 32'h2000 + 32'(i), 1'b0, 32'hBB);
`ifdef DCACHE_ARB_ROUND_ROBIN_EN
      g = i % 2;
`else
      g = 0;
`endif
      #1;
      chk("tie_m0_ready", {31'd0, m0_ready}, (g == 0) ? 32'd1 : 32'd0);
      chk("tie_m1_ready", {31'd0, m1_ready}, (g == 1) ? 32'd1 : 32'd0);
      chk("tie_dc_address", dc_address, (g == 1) ? 32'h2000 + 32'(i) : 32'h1000 + 32'(i));
    end
    @(posedge clock);
    #1;
    drive(0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);

    // Single m0 read, m1 idle
    @(negedge clock);
    drive(0, 1'b1, 1'b0, 32'h100, 1'b0, 32'h15);
    #1;
    chk("rd_dc_request", {31'd0, dc_request}, 32'd1);
    chk("rd_dc_address", dc_address, 32'h100);
    chk("rd_dc_tag", {23'd0, dc_wdata[8:0]}, 32'h15);
    chk("rd_m0_ready", {31'd0, m0_ready}, 32'd1);
    @(posedge clock);
    #1;
    drive(0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    @(negedge clock);
    #1;
    chk("rd_dc_request_one_cycle", {31'd0, dc_request}, 32'd0);
    wait_drain();

    // m1 4-beat write burst; m0 requests from beat 2 and must wait for the last beat
    beat(1, 1'b1, 32'h200, 1'b1, 32'hD0);
    for (int b = 1; b < 4; b++) begin
      @(negedge clock);
      drive(1, 1'b1, 1'b1, 32'h200 + 32'(4 * b), (b < 3), 32'hD0 + 32'(b));
      drive(0, 1'b1, 1'b0, 32'h300, 1'b0, 32'h16);
      #1;
      chk("lock_m0_ready", {31'd0, m0_ready}, 32'd0);
      chk("lock_m1_ready", {31'd0, m1_ready}, 32'd1);
      chk("lock_dc_address", dc_address, 32'h200 + 32'(4 * b));
    end
    @(posedge clock);
    #1;
    drive(1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    @(negedge clock);
    #1;
    chk("unlock_m0_ready", {31'd0, m0_ready}, 32'd1);
    chk("unlock_dc_address", dc_address, 32'h300);
    @(posedge clock);
    #1;
    drive(0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    wait_drain();

    // Four back-to-back reads fill the ID FIFO; the fifth stalls until the first response
    lat = 3;
    beat(0, 1'b0, 32'h800, 1'b0, 32'h21);
    beat(1, 1'b0, 32'h804, 1'b0, 32'h22);
    beat(0, 1'b0, 32'h808, 1'b0, 32'h23);
    beat(1, 1'b0, 32'h80C, 1'b0, 32'h24);
    @(negedge clock);
    drive(0, 1'b1, 1'b0, 32'h900, 1'b0, 32'h25);
    #1;
    chk("full_m0_ready", {31'd0, m0_ready}, 32'd0);
    chk("full_dc_request", {31'd0, dc_request}, 32'd0);
    @(negedge clock);
    #1;
    chk("full_release_m0_ready", {31'd0, m0_ready}, 32'd1);
    @(posedge clock);
    #1;
    drive(0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    wait_drain();

    // Reset mid-burst with two reads outstanding
    lat = 8;
    beat(0, 1'b0, 32'h400, 1'b0, 32'h31);
    beat(1, 1'b0, 32'h404, 1'b0, 32'h32);
    beat(1, 1'b1, 32'h500, 1'b1, 32'h0);
    @(negedge clock);
    drive(1, 1'b1, 1'b1, 32'h504, 1'b1, 32'h0);
    drive(0, 1'b1, 1'b0, 32'h600, 1'b0, 32'h33);
    #3;
    reset = 1'b0;
    sb.delete();
    #1;
    chk("arst_dc_request", {31'd0, dc_request}, 32'd0);
    chk("arst_m0_ready", {31'd0, m0_ready}, 32'd0);
    chk("arst_m1_ready", {31'd0, m1_ready}, 32'd0);
    chk("arst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    chk("arst_m0_rdata", m0_rdata, 32'd0);
    chk("arst_m1_rdata", m1_rdata, 32'd0);
    chk("arst_rtag", {23'd0, m0_rtag | m1_rtag}, 32'd0);
    repeat (2) @(negedge clock);
    drive(0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    reset = 1'b1;
    rv_before = rv_count;
    for (int i = 0; i < 40; i++) begin
      if (dq.size() == 0) break;
      @(posedge clock);
    end
    repeat (3) @(posedge clock);
    chk("stale_delivered", dq.size(), 32'd0);
    chk("stale_dropped", rv_count, rv_before);

    lat = 2;
    beat(0, 1'b0, 32'h700, 1'b0, 32'h44);
    beat(1, 1'b0, 32'h704, 1'b0, 32'h1AB);
    wait_drain();
    chk("final_rsp_count", rv_count - rv_before, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
